// File: rtl/uart_autobaud.sv
// Auto-baud detector: times the UART start bit and reports the half-bit divisor.
// Define AUTOBAUD_CHECK_EN to also time the following high bit and reject mismatches.
module uart_autobaud #(
  parameter int unsigned MIN_PULSE = 4,
  parameter logic [31:0] TIMEOUT   = 32'd16777216
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        rx,
  output logic [31:0] divisor,
  output logic        valid,
  output logic        error,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_IDLE,
    WAIT_FALL,
    MEAS_LOW,
`ifdef AUTOBAUD_CHECK_EN
    MEAS_HIGH,
`endif
    RESULT
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] nlow_q, nlow_d;
  logic [31:0] div_q, div_d;
  logic        valid_q, valid_d;
  logic        error_q, error_d;
  logic        rx_meta_q, rx_s_q;
  logic [32:0] half_sum;
  logic        accept;

  // Round half up; the extra bit keeps N_low = 2^32-1 from wrapping.
  assign half_sum = {1'b0, nlow_q} + 33'd1;

`ifdef AUTOBAUD_CHECK_EN
  logic [31:0] nhigh_q, nhigh_d;
  logic [31:0] diff;
  assign diff   = (nhigh_q >= nlow_q) ? (nhigh_q - nlow_q) : (nlow_q - nhigh_q);
  assign accept = (nlow_q >= 32'(MIN_PULSE)) && (diff <= (nlow_q >> 2));
`else
  assign accept = (nlow_q >= 32'(MIN_PULSE));
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      nlow_q    <= '0;
      div_q     <= '0;
      valid_q   <= 1'b0;
      error_q   <= 1'b0;
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
`ifdef AUTOBAUD_CHECK_EN
      nhigh_q   <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      nlow_q    <= nlow_d;
      div_q     <= div_d;
      valid_q   <= valid_d;
      error_q   <= error_d;
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
`ifdef AUTOBAUD_CHECK_EN
      nhigh_q   <= nhigh_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    nlow_d  = nlow_q;
    div_d   = div_q;
    valid_d = 1'b0;
    error_d = 1'b0;
`ifdef AUTOBAUD_CHECK_EN
    nhigh_d = nhigh_q;
`endif
    case (state_q)
      IDLE:      if (start) state_d = WAIT_IDLE;
      // A line already low at arm time is not a start bit we can time.
      WAIT_IDLE: if (rx_s_q) state_d = WAIT_FALL;
      WAIT_FALL: if (!rx_s_q) begin
        state_d = MEAS_LOW;
        cnt_d   = 32'd1;
      end
      MEAS_LOW: begin
        if (rx_s_q) begin
          nlow_d  = cnt_q;
`ifdef AUTOBAUD_CHECK_EN
          state_d = MEAS_HIGH;
          cnt_d   = 32'd1;
`else
          state_d = RESULT;
`endif
        end else if (cnt_q >= TIMEOUT) begin
          error_d = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
`ifdef AUTOBAUD_CHECK_EN
      MEAS_HIGH: begin
        if (!rx_s_q) begin
          nhigh_d = cnt_q;
          state_d = RESULT;
        end else if (cnt_q >= TIMEOUT) begin
          error_d = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
`endif
      RESULT: begin
        if (accept) begin
          div_d   = half_sum[32:1];
          valid_d = 1'b1;
        end else begin
          error_d = 1'b1;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign divisor = div_q;
  assign valid   = valid_q;
  assign error   = error_q;
  assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_uart_autobaud.sv
// Directed bench for uart_autobaud: expected pulses are queued at stimulus time
// and matched (kind, divisor, arrival cycle) when valid/error fires.
module tb_uart_autobaud;
  localparam int          MINP = 4;
  localparam logic [31:0] TMO  = 32'd1000;

  logic        clk = 1'b0;
  logic        reset, start, rx;
  logic [31:0] divisor;
  logic        valid, error, busy;

  uart_autobaud #(.MIN_PULSE(MINP), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .start(start), .rx(rx),
    .divisor(divisor), .valid(valid), .error(error), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_err;
    logic [31:0] div;
    int          at;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(bit e, logic [31:0] d, int at);
    exp_t x;
    x.is_err = e;
    x.div    = d;
    x.at     = at;
    sb.push_back(x);
  endtask

  task automatic drain(int budget);
    int i = 0;
    while (sb.size() != 0 && i < budget) begin
      step(1);
      i++;
    end
    chk("drain_timeout", 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  task automatic arm();
    start = 1'b1;
    step(1);
    start = 1'b0;
    chk("busy_armed", 32'(busy), 32'd1);
  endtask

  // Low pulse n, high pulse h, then a short low so the high pulse is terminated.
  task automatic frame(int n, int h, bit e, logic [31:0] d);
`ifdef AUTOBAUD_CHECK_EN
    push(e, d, cyc + 1 + n + h + 3);
`else
    push(e, d, cyc + 1 + n + 3);
`endif
    rx = 1'b0;
    step(n);
    rx = 1'b1;
    step(h);
    rx = 1'b0;
    step(4);
    rx = 1'b1;
    drain(n + h + 50);
  endtask

  task automatic measure(int n, int h, bit e, logic [31:0] d);
    arm();
    rx = 1'b1;
    step(10);
    frame(n, h, e, d);
  endtask

  always @(negedge clk) begin
    if (valid || error) begin
      exp_t e;
      chk("both_pulses", 32'(valid & error), 32'd0);
      chk("pulse_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("pulse_kind", 32'(error), 32'(e.is_err));
        chk("divisor", divisor, e.div);
        chk("latency", 32'(cyc), 32'(e.at));
        chk("busy_at_pulse", 32'(busy), 32'd0);
      end
    end
  end

  initial begin
    logic [9:0] sync55;
    int         t0;
    reset = 1'b1;
    start = 1'b0;
    rx    = 1'b1;
    step(3);
    chk("rst_divisor", divisor, 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    step(2);

    // Nominal 868-cycle start bit.
    measure(868, 868, 1'b0, 32'd434);
    chk("busy_idle_after", 32'(busy), 32'd0);

    // Too short: rejected, divisor unchanged.
    measure(3, 3, 1'b1, 32'd434);

    // Shortest accepted pulse and odd-length rounding.
    measure(MINP, MINP, 1'b0, 32'd2);
    measure(5, 5, 1'b0, 32'd3);

    // Line low at arm time: that low period must be skipped.
    rx = 1'b0;
    step(5);
    arm();
    step(50);
    chk("busy_wait_idle", 32'(busy), 32'd1);
    rx = 1'b1;
    step(20);
    frame(100, 100, 1'b0, 32'd50);

    // Stuck-low line hits the timeout.
    arm();
    rx = 1'b1;
    step(10);
    push(1'b1, 32'd50, cyc + 1 + int'(TMO) + 2);
    rx = 1'b0;
    step(500);
    chk("busy_measuring", 32'(busy), 32'd1);
    step(600);
    rx = 1'b1;
    drain(50);
    chk("busy_after_timeout", 32'(busy), 32'd0);

    // Reset mid-measurement, then a clean 0x55 at 100 cycles per bit.
    arm();
    rx = 1'b1;
    step(10);
    rx = 1'b0;
    step(203);
    reset = 1'b1;
    step(1);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_divisor", divisor, 32'd0);
    chk("midrst_valid", 32'(valid), 32'd0);
    chk("midrst_error", 32'(error), 32'd0);
    rx = 1'b1;
    step(3);
    reset = 1'b0;
    step(2);
    arm();
    step(10);
`ifdef AUTOBAUD_CHECK_EN
    push(1'b0, 32'd50, cyc + 1 + 100 + 100 + 3);
`else
    push(1'b0, 32'd50, cyc + 1 + 100 + 3);
`endif
    sync55 = 10'b1010101010;
    for (int i = 0; i < 10; i++) begin
      rx = sync55[i];
      step(100);
    end
    rx = 1'b1;
    drain(100);

`ifdef AUTOBAUD_CHECK_EN
    measure(100, 140, 1'b1, 32'd50);
    measure(100, 120, 1'b0, 32'd50);
`endif

    t0 = cyc;
    step(20);
    chk("no_stray_pulses", 32'(sb.size()), 32'd0);
    chk("bench_time_advanced", 32'(cyc - t0), 32'd20);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
